// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port fixed-latency memory
//
// Purpose:
//   Shares one single-port unified memory between instruction fetch and
//   MEM-stage loads/stores. Each granted access occupies MEM_LAT ACCESS cycles,
//   followed by a one-cycle RESP cycle that carries the ready pulse and the
//   registered read data. The data side has priority. A starvation counter
//   forces a fetch grant after STARVE_MAX consecutive data grants taken while
//   fetch was waiting.
//
// Optional feature:
//   MEM_ARB_PERF_EN adds the saturating wait counters perf_if_wait and
//   perf_d_wait.
//
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   if_req/if_addr               fetch request; if_rdata/if_ready completion
//   d_req/d_we/d_addr/d_wdata    data request; d_rdata/d_ready completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   stall_if, stall_mem          combinational stalls to the pipeline
//   busy                         FSM is not in IDLE
//   perf_if_wait, perf_d_wait    stall-cycle counters (MEM_ARB_PERF_EN only)

module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          starve_q, starve_d;
  logic                sel_data_q, sel_data_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                grant_data;

  // Data wins unless fetch is waiting and has already been passed over
  // STARVE_MAX times in a row.
  assign grant_data = d_req && (!if_req || (starve_q < STARVE_LIM));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    sel_data_d  = sel_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d    = S_ACCESS;
          cnt_d      = 4'd0;
          sel_data_d = 1'b1;
          mem_en_d   = 1'b1;
          mem_we_d   = d_we;
          mem_addr_d = d_addr;
          if (d_we) begin
            mem_wdata_d = d_wdata;
          end
          if (if_req) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (if_req) begin
          state_d    = S_ACCESS;
          cnt_d      = 4'd0;
          sel_data_d = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
          starve_d   = 4'd0;
        end
      end

      S_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          // mem_rdata is valid in the last ACCESS cycle; capture it here.
          state_d = S_RESP;
          if (sel_data_q) begin
            d_ready_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          cnt_d    = cnt_q + 4'd1;
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      sel_data_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      sel_data_q  <= sel_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign busy      = (state_q != S_IDLE);

  // Gated by reset so the pipeline is never stalled while reset is held.
  assign stall_if  = reset & if_req & ~if_ready_q;
  assign stall_mem = reset & d_req & ~d_ready_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_d_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_q <= 32'd0;
      perf_d_q  <= 32'd0;
    end else begin
      if (stall_if && (perf_if_q != 32'hFFFF_FFFF)) begin
        perf_if_q <= perf_if_q + 32'd1;
      end
      if (stall_mem && (perf_d_q != 32'hFFFF_FFFF)) begin
        perf_d_q <= perf_d_q + 32'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_d_wait  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_d_wait;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
  );

  // Memory model: unwritten words return a fixed pattern, word 0x20 is preloaded.
  bit [63:0] mem [0:255];
  bit        wr_v [0:255];
  logic [7:0] ridx;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[10:3]]  <= mem_wdata;
      wr_v[mem_addr[10:3]] <= 1'b1;
    end
  end

  always_comb begin
    ridx = mem_addr[10:3];
    if (wr_v[ridx]) mem_rdata = mem[ridx];
    else if (ridx == 8'h20) mem_rdata = 64'h1111_2222_3333_4444;
    else mem_rdata = {24'hA5A500, ridx, 24'h5A5A00, ridx};
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [63:0] rd;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[8];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic pop_check(input bit is_d);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("sb_side", {63'd0, is_d}, {63'd0, e.is_d});
      chk("sb_rdata", is_d ? d_rdata : {32'd0, if_rdata}, e.rd);
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    e.is_d = v.is_d;
    e.rd   = v.exp;
    sbq.push_back(e);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk("stall_c0", v.is_d ? {63'd0, stall_mem} : {63'd0, stall_if}, 64'd1);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      chk("mem_en", {63'd0, mem_en}, {63'd0, (c <= LAT)});
      if (c <= LAT) begin
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", {63'd0, mem_we}, {63'd0, v.we});
        if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
      end
      chk("ready", v.is_d ? {63'd0, d_ready} : {63'd0, if_ready}, {63'd0, (c == LAT + 1)});
      if (c == LAT + 1) pop_check(v.is_d);
    end
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    tbl[0] = '{1'b0, 1'b0, 64'h100, 64'h0, 64'h3333_4444};
    tbl[1] = '{1'b0, 1'b0, 64'h104, 64'h0, 64'h1111_2222};
    tbl[2] = '{1'b1, 1'b1, 64'h40,  64'hDEAD_BEEF, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 64'h40,  64'h0, 64'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b0, 64'h48,  64'h0, 64'hA5A5_0009_5A5A_0009};
    tbl[5] = '{1'b1, 1'b1, 64'h48,  64'h0123_4567_89AB_CDEF, 64'hA5A5_0009_5A5A_0009};
    tbl[6] = '{1'b1, 1'b0, 64'h48,  64'h0, 64'h0123_4567_89AB_CDEF};
    tbl[7] = '{1'b0, 1'b0, 64'h4C,  64'h0, 64'h0123_4567};

    // Reset held for two cycles with both requests high.
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 64'h100; d_addr = 64'h40; d_wdata = 64'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_readys", {62'd0, if_ready, d_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stalls", {62'd0, stall_if, stall_mem}, 64'd0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single-requester table.
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Simultaneous requests: data first, fetch follows.
    begin
      exp_t e;
      e.is_d = 1'b1; e.rd = 64'h0123_4567_89AB_CDEF; sbq.push_back(e);
      e.is_d = 1'b0; e.rd = 64'h3333_4444;           sbq.push_back(e);
    end
    if_req = 1'b1; if_addr = 64'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
    #1;
    chk("both_stall_if_c0", {63'd0, stall_if}, 64'd1);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      chk("both_mem_en", {63'd0, mem_en}, {63'd0, (c == 1 || c == 2 || c == 5 || c == 6)});
      chk("both_d_ready", {63'd0, d_ready}, {63'd0, (c == 3)});
      chk("both_if_ready", {63'd0, if_ready}, {63'd0, (c == 7)});
      chk("both_stall_if", {63'd0, stall_if}, {63'd0, (c <= 6)});
      if (c == 1) chk("both_addr_d", mem_addr, 64'h48);
      if (c == 5) chk("both_addr_f", mem_addr, 64'h100);
      if (c == 3) begin pop_check(1'b1); d_req = 1'b0; end
      if (c == 7) begin pop_check(1'b0); if_req = 1'b0; end
    end
    @(posedge clk); #1;

    // Starvation guard: both held high; four data grants, one fetch, then data.
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.is_d = (k != SMAX);
      e.rd   = (k != SMAX) ? 64'h0123_4567_89AB_CDEF : 64'h1111_2222;
      sbq.push_back(e);
    end
    if_req = 1'b1; if_addr = 64'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
    for (int k = 0; k < 6; k++) begin
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!(d_ready || if_ready) && t < 20);
      if (!(d_ready || if_ready)) begin
        chk("starve_timeout", 64'd1, 64'd0);
      end else begin
        chk("starve_gap", 64'(t), 64'((k == 0) ? LAT + 1 : LAT + 2));
        pop_check(d_ready);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Reset during the first ACCESS cycle of a store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h50; d_wdata = 64'hCAFE;
    @(posedge clk); #1;
    chk("mr_we_c1", {63'd0, mem_we}, 64'd1);
    chk("mr_busy_c1", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mr_stall_in_rst", {63'd0, stall_mem}, 64'd0);
    @(posedge clk); #1;
    chk("mr_we_c2", {63'd0, mem_we}, 64'd0);
    chk("mr_en_c2", {63'd0, mem_en}, 64'd0);
    chk("mr_busy_c2", {63'd0, busy}, 64'd0);
    chk("mr_d_rdata", d_rdata, 64'd0);
    chk("mr_if_rdata", {32'd0, if_rdata}, 64'd0);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mr_no_ready", {62'd0, d_ready, busy}, 64'd0);
    end
    run_txn(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the MEM stage (data loads/stores) of the five-stage pipeline.
- Sequences each access over MEM_LAT cycles and returns a one-cycle ready pulse with registered read data.
- Drives stall requests back to the pipeline while a requester waits.
- Data side has priority; a starvation guard ensures fetch still makes progress.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory port
- DATA_W, 64, memory word width; fetch returns a 32-bit half-word slice
- MEM_LAT, 2, memory access cycles per transfer; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  instruction word
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid during the last ACCESS cycle
- stall_if  out  1  fetch stall
- stall_mem  out  1  MEM-stage stall
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset: reset is sampled low at a clk edge. Effects:
  - FSM goes to IDLE; cycle counter and starvation counter go to 0.
  - All registered outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready.
  - Applies mid-access: the in-flight access is dropped, no ready pulse is issued, and mem_we is 0 from the first cycle after the reset edge.
- FSM states:
  - IDLE: a request sampled high in IDLE is a new request.
  - ACCESS: lasts exactly MEM_LAT cycles, tracked by the cycle counter.
  - RESP: lasts one cycle; the selected ready is high. RESP always returns to IDLE.
- Grant at the IDLE edge:
  - If d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX), data is granted.
  - Else if if_req=1, fetch is granted.
  - Else stay in IDLE.
  - At grant, the address (plus d_we and d_wdata for data) and the granted-side flag are latched. Later input changes are ignored until RESP.
- Starvation counter:
  - A data grant with if_req=1 increments it (saturating at 15).
  - A data grant with if_req=0, or any fetch grant, clears it to 0.
- ACCESS outputs:
  - mem_en=1 and mem_addr = latched address.
  - For a store: mem_we=1 and mem_wdata = latched data on every ACCESS cycle.
  - For a load or fetch: mem_we=0.
  - Outside ACCESS: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
- Read capture (last ACCESS cycle edge):
  - Data load: d_rdata <= mem_rdata.
  - Fetch: if_rdata <= latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - rdata registers hold until the next capture; a store leaves d_rdata unchanged.
- Latency: a request is sampled in IDLE at cycle 0. ACCESS spans cycles 1..MEM_LAT; ready is asserted at cycle MEM_LAT+1. Peak throughput is one transfer per MEM_LAT+2 cycles.
- Requester protocol: hold req, addr and data stable until ready. Drop req in the cycle after ready unless a new request is intended; req high in the following IDLE cycle is treated as a new request.
- Stall outputs (combinational):
  - stall_if = if_req & ~if_ready
  - stall_mem = d_req & ~d_ready
  - Both are 0 while reset is low.
- Address bits below 2 are passed through unmodified; alignment is the requester's responsibility.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, two extra outputs are added:
  - perf_if_wait (out, 32): counts cycles with stall_if=1.
  - perf_d_wait (out, 32): counts cycles with stall_mem=1.
  - Both saturate at 0xFFFFFFFF and are cleared by reset.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Hold reset=0 for 2 cycles with both req=1 -> all outputs 0, busy=0, stall_if=stall_mem=0, no mem_en.
- Fetch if_addr=0x100, mem_rdata=0x11112222_33334444 -> mem_en in cycles 1-2, if_ready in cycle 3, if_rdata=0x33334444. Repeat with if_addr=0x104 -> if_rdata=0x11112222.
- Store 0xDEADBEEF to d_addr=0x40, then load 0x40 (memory model returns the stored value) -> store: mem_we=1 in cycles 1-2, d_ready in cycle 3, d_rdata unchanged; load: d_rdata=0xDEADBEEF at d_ready.
- if_req and d_req both rise at cycle 0 -> data ACCESS in cycles 1-2, d_ready in cycle 3, fetch ACCESS in cycles 5-6, if_ready in cycle 7; stall_if=1 in cycles 0-6.
- if_req held high, d_req re-asserted in every IDLE cycle (STARVE_MAX=4) -> four data grants, fifth grant goes to fetch, then data resumes.
- reset=0 in cycle 1 of a store -> mem_we=0 from cycle 2, no d_ready, state IDLE; a new fetch after reset release completes normally.
